// File: rtl/rc4_encrypt_if.sv
// Bundle of the RC4 encrypt engine's control handshake and its three RAM ports.
// The master side is the engine; the slave side is whatever owns the RAMs and start.
interface rc4_encrypt_if #(
  parameter int MSG_AW = 5
);
  logic              start;
  logic [23:0]       secret_key;
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] pt_addr;
  logic [7:0]        pt_rdata;
  logic [MSG_AW-1:0] ct_addr;
  logic [7:0]        ct_wdata;
  logic              ct_wren;
  logic              busy;
  logic              done;

  modport master (
    input  start, secret_key, s_rdata, pt_rdata,
    output s_addr, s_wdata, s_wren, pt_addr, ct_addr, ct_wdata, ct_wren, busy, done
  );

  modport slave (
    output start, secret_key, s_rdata, pt_rdata,
    input  s_addr, s_wdata, s_wren, pt_addr, ct_addr, ct_wdata, ct_wren, busy, done
  );
endinterface

// File: rtl/rc4_encrypt_fsm.sv
// RC4 encryptor: S-box init, key schedule, then keystream XOR of the plaintext RAM
// into the ciphertext RAM. All RAMs have a registered address and unregistered data.
module rc4_encrypt_fsm #(
  parameter int MSG_LEN = 32,
  parameter int KEY_LEN = 3,
  parameter int MSG_AW  = 5
) (
  input  logic       clk,
  input  logic       rst,
  rc4_encrypt_if.master bus
);

  localparam logic [MSG_AW-1:0] LAST_K   = MSG_AW'(MSG_LEN - 1);
  localparam logic [MSG_AW-1:0] K_ONE    = MSG_AW'(1'b1);
  localparam logic [1:0]        KEY_LAST = 2'(KEY_LEN - 1);

  typedef enum logic [4:0] {
    IDLE     = 5'd0,
    INIT     = 5'd1,
    KSA_RI   = 5'd2,
    KSA_WI   = 5'd3,
    KSA_J    = 5'd4,
    KSA_WJ   = 5'd5,
    KSA_SW1  = 5'd6,
    KSA_SW2  = 5'd7,
    PRGA_I   = 5'd8,
    PRGA_WI  = 5'd9,
    PRGA_J   = 5'd10,
    PRGA_WJ  = 5'd11,
    PRGA_SW1 = 5'd12,
    PRGA_SW2 = 5'd13,
    PRGA_RF  = 5'd14,
    PRGA_WF  = 5'd15,
    PRGA_CT  = 5'd16,
    DONE     = 5'd17
  } state_t;

  state_t            state_r;
  logic [23:0]       key_r;
  logic [1:0]        key_idx_r;
  logic [7:0]        i_r;
  logic [7:0]        j_r;
  logic [MSG_AW-1:0] k_r;
  logic [7:0]        si_r;
  logic [7:0]        sj_r;

  logic [7:0]        key_byte_s;
  logic [1:0]        key_idx_inc_s;
  logic [7:0]        i_inc_s;
  logic [7:0]        ksa_j_s;
  logic [7:0]        prga_j_s;
  logic [7:0]        f_addr_s;

  // Key byte 0 is the most significant byte of the latched key.
  function automatic logic [7:0] key_sel(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_sel = key[23:16];
      2'd1:    key_sel = key[15:8];
      2'd2:    key_sel = key[7:0];
      default: key_sel = 8'd0;
    endcase
  endfunction

  // Next-index arithmetic; everything wraps modulo 256.
  always_comb begin
    key_byte_s = key_sel(key_r, key_idx_r);
    if (key_idx_r == KEY_LAST) begin
      key_idx_inc_s = 2'd0;
    end else begin
      key_idx_inc_s = key_idx_r + 2'd1;
    end
    i_inc_s  = i_r + 8'd1;
    ksa_j_s  = j_r + bus.s_rdata + key_byte_s;
    prga_j_s = j_r + bus.s_rdata;
    f_addr_s = si_r + sj_r;
  end

  // Sequencer: every RAM read is address, one wait state, then sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      key_r          <= 24'd0;
      key_idx_r      <= 2'd0;
      i_r            <= 8'd0;
      j_r            <= 8'd0;
      k_r            <= {MSG_AW{1'b0}};
      si_r           <= 8'd0;
      sj_r           <= 8'd0;
      bus.s_addr     <= 8'd0;
      bus.s_wdata    <= 8'd0;
      bus.s_wren     <= 1'b0;
      bus.pt_addr    <= {MSG_AW{1'b0}};
      bus.ct_addr    <= {MSG_AW{1'b0}};
      bus.ct_wdata   <= 8'd0;
      bus.ct_wren    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.s_wren  <= 1'b0;
      bus.ct_wren <= 1'b0;
      bus.done    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            key_r    <= bus.secret_key;
            i_r      <= 8'd0;
            bus.busy <= 1'b1;
            state_r  <= INIT;
          end else begin
            state_r  <= IDLE;
          end
        end
        INIT: begin
          bus.s_addr  <= i_r;
          bus.s_wdata <= i_r;
          bus.s_wren  <= 1'b1;
          i_r         <= i_inc_s;
          if (i_r == 8'hFF) begin
            j_r       <= 8'd0;
            key_idx_r <= 2'd0;
            state_r   <= KSA_RI;
          end else begin
            state_r   <= INIT;
          end
        end
        KSA_RI: begin
          bus.s_addr <= i_r;
          state_r    <= KSA_WI;
        end
        KSA_WI: begin
          state_r <= KSA_J;
        end
        KSA_J: begin
          si_r       <= bus.s_rdata;
          j_r        <= ksa_j_s;
          bus.s_addr <= ksa_j_s;
          state_r    <= KSA_WJ;
        end
        KSA_WJ: begin
          state_r <= KSA_SW1;
        end
        KSA_SW1: begin
          bus.s_addr  <= i_r;
          bus.s_wdata <= bus.s_rdata;
          bus.s_wren  <= 1'b1;
          state_r     <= KSA_SW2;
        end
        KSA_SW2: begin
          bus.s_addr  <= j_r;
          bus.s_wdata <= si_r;
          bus.s_wren  <= 1'b1;
          i_r         <= i_inc_s;
          key_idx_r   <= key_idx_inc_s;
          if (i_r == 8'hFF) begin
            j_r     <= 8'd0;
            k_r     <= {MSG_AW{1'b0}};
            state_r <= PRGA_I;
          end else begin
            state_r <= KSA_RI;
          end
        end
        PRGA_I: begin
          i_r        <= i_inc_s;
          bus.s_addr <= i_inc_s;
          state_r    <= PRGA_WI;
        end
        PRGA_WI: begin
          state_r <= PRGA_J;
        end
        PRGA_J: begin
          si_r       <= bus.s_rdata;
          j_r        <= prga_j_s;
          bus.s_addr <= prga_j_s;
          state_r    <= PRGA_WJ;
        end
        PRGA_WJ: begin
          state_r <= PRGA_SW1;
        end
        PRGA_SW1: begin
          sj_r        <= bus.s_rdata;
          bus.s_addr  <= i_r;
          bus.s_wdata <= bus.s_rdata;
          bus.s_wren  <= 1'b1;
          state_r     <= PRGA_SW2;
        end
        PRGA_SW2: begin
          bus.s_addr  <= j_r;
          bus.s_wdata <= si_r;
          bus.s_wren  <= 1'b1;
          state_r     <= PRGA_RF;
        end
        // The swap exchanges the two values, so their sum is unchanged.
        PRGA_RF: begin
          bus.s_addr  <= f_addr_s;
          bus.pt_addr <= k_r;
          state_r     <= PRGA_WF;
        end
        PRGA_WF: begin
          state_r <= PRGA_CT;
        end
        PRGA_CT: begin
          bus.ct_addr  <= k_r;
          bus.ct_wdata <= bus.s_rdata ^ bus.pt_rdata;
          bus.ct_wren  <= 1'b1;
          if (k_r == LAST_K) begin
            state_r <= DONE;
          end else begin
            k_r     <= k_r + K_ONE;
            state_r <= PRGA_I;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
